// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch-side initiator for a byte-addressable, big-endian instruction memory
//   with a combinational read port. It holds the program counter, presents it
//   as the fetch address, and registers one 16-bit instruction per cycle into
//   a single output slot that decode drains with a valid/ready handshake.
//   It also handles branch redirects, detection of the halt opcode, and faults
//   on misaligned or out-of-range redirect targets.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous active-high reset
//   imem_addr      out  16  byte address to instruction memory (== pc)
//   imem_data      in   16  instruction word for imem_addr, same cycle
//   ir_data        out  16  registered instruction for decode
//   ir_pc          out  16  byte address that ir_data was fetched from
//   ir_valid       out  1   ir_data/ir_pc valid
//   ir_ready       in   1   decode accepts the slot when ir_valid=1
//   redirect_valid in   1   load redirect_pc as next fetch address, flush slot
//   redirect_pc    in   16  redirect target byte address
//   pc             out  16  current fetch address register
//   halted         out  1   HALT state
//   fault          out  1   FAULT state (sticky until rst)
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_BYTES   = 256,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ir_data,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc,
  output logic        halted,
  output logic        fault
);

  // Highest legal (even) fetch address, and the mask that wraps the PC
  // modulo the memory size.
  localparam logic [15:0] MAX_PC    = 16'(MEM_BYTES - 2);
  localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir_data;
  logic [15:0] r_ir_pc;
  logic        r_ir_valid;
  logic        r_halted;
  logic        r_fault;

  logic        w_slot_free;
  logic        w_accept;
  logic        w_redirect_bad;
  logic [15:0] w_pc_inc;
  logic        w_is_halt;

  assign w_slot_free    = !r_ir_valid || ir_ready;
  assign w_accept       = r_ir_valid && ir_ready;
  assign w_redirect_bad = redirect_pc[0] || (redirect_pc > MAX_PC);
  assign w_pc_inc       = (r_pc + 16'd2) & ADDR_MASK;
  assign w_is_halt      = (imem_data[15:12] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir_data  <= 16'h0000;
      r_ir_pc    <= 16'h0000;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (redirect_valid) begin
            // A redirect discards whatever sits in the slot, even if decode
            // has not taken it; nothing is captured this cycle.
            r_ir_valid <= 1'b0;
            if (w_redirect_bad) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_pc <= redirect_pc;
            end
          end else if (w_slot_free) begin
            r_ir_data  <= imem_data;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= w_pc_inc;
            // The halt word itself is still delivered to decode.
            if (w_is_halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end
          // Otherwise stalled: every register holds.
        end

        S_HALT: begin
          if (redirect_valid) begin
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
            if (w_redirect_bad) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              r_pc    <= redirect_pc;
            end
          end else if (w_accept) begin
            // Pending halt word drained; no further captures.
            r_ir_valid <= 1'b0;
          end
        end

        S_FAULT: begin
          // Terminal until reset; pc and the fetch address are frozen.
          r_ir_valid <= 1'b0;
        end

        default: begin
          r_state    <= S_FAULT;
          r_fault    <= 1'b1;
          r_halted   <= 1'b0;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir_data   = r_ir_data;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_ir_valid;
  assign halted    = r_halted;
  assign fault     = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch with a 256-byte big-endian memory
//   model. Inputs change 1 ns after each rising edge; outputs are checked at
//   the same point, reflecting the state produced by that edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic        halted;
  logic        fault;

  logic [7:0]  mem [0:255];
  logic [7:0]  a_lo;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(
    .RESET_PC   (16'h0000),
    .MEM_BYTES  (256),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .halted        (halted),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational big-endian memory read.
  assign a_lo      = imem_addr[7:0];
  assign imem_data = {mem[a_lo], mem[a_lo + 8'd1]};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b rdy=%0b redir=%0b/%h -> pc=%h v=%0b ir=%h@%h halt=%0b fault=%0b",
             $time, rst, ir_ready, redirect_valid, redirect_pc, pc, ir_valid, ir_data, ir_pc,
             halted, fault);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hD1; mem[8'h01] = 8'h18;
    mem[8'h02] = 8'h12; mem[8'h03] = 8'h34;
    mem[8'h04] = 8'hF0; mem[8'h05] = 8'h00;
    mem[8'h40] = 8'h12; mem[8'h41] = 8'h00;
    mem[8'hFE] = 8'hA5; mem[8'hFF] = 8'h5A;

    rst = 1'b1; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    step();
    step();
    // Reset state
    chk("rst_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_data", ir_data, 16'h0000);
    chk("rst_irpc", ir_pc, 16'h0000);
    chk("rst_halt", {15'd0, halted}, 16'd0);
    chk("rst_fault", {15'd0, fault}, 16'd0);

    // 1: first fetch lands one cycle after reset release
    rst = 1'b0; ir_ready = 1'b1;
    step();
    chk("t1_valid", {15'd0, ir_valid}, 16'd1);
    chk("t1_data0", ir_data, 16'hD118);
    chk("t1_irpc0", ir_pc, 16'h0000);
    chk("t1_addr2", imem_addr, 16'h0002);

    // 2: stall for three cycles, slot and pc frozen
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_stall_data", ir_data, 16'hD118);
      chk("t2_stall_irpc", ir_pc, 16'h0000);
      chk("t2_stall_pc", pc, 16'h0002);
      chk("t2_stall_valid", {15'd0, ir_valid}, 16'd1);
    end
    ir_ready = 1'b1;
    step();
    chk("t2_data1", ir_data, 16'h1234);
    chk("t2_irpc1", ir_pc, 16'h0002);
    chk("t2_addr4", imem_addr, 16'h0004);

    // 3: redirect flushes an unaccepted word
    ir_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    chk("t3_flush", {15'd0, ir_valid}, 16'd0);
    chk("t3_addr", imem_addr, 16'h0040);
    redirect_valid = 1'b0; ir_ready = 1'b1;
    step();
    chk("t3_irpc", ir_pc, 16'h0040);
    chk("t3_data", ir_data, 16'h1200);
    chk("t3_pc", pc, 16'h0042);

    // 4: halt word delivered then fetching stops
    redirect_valid = 1'b1; redirect_pc = 16'h0004;
    step();
    chk("t4_redir_pc", pc, 16'h0004);
    redirect_valid = 1'b0;
    step();
    chk("t4_hdata", ir_data, 16'hF000);
    chk("t4_hirpc", ir_pc, 16'h0004);
    chk("t4_hvalid", {15'd0, ir_valid}, 16'd1);
    chk("t4_halted", {15'd0, halted}, 16'd1);
    chk("t4_pc6", pc, 16'h0006);
    step();
    chk("t4_drained", {15'd0, ir_valid}, 16'd0);
    step();
    chk("t4_novalid", {15'd0, ir_valid}, 16'd0);
    chk("t4_pc_hold", pc, 16'h0006);
    chk("t4_still_halt", {15'd0, halted}, 16'd1);
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    step();
    chk("t4_unhalt", {15'd0, halted}, 16'd0);
    chk("t4_pc0", pc, 16'h0000);
    redirect_valid = 1'b0;
    step();
    chk("t4_resume_data", ir_data, 16'hD118);
    chk("t4_resume_irpc", ir_pc, 16'h0000);
    chk("t4_resume_valid", {15'd0, ir_valid}, 16'd1);

    // 5: misaligned redirect faults, pc holds, only reset clears
    redirect_valid = 1'b1; redirect_pc = 16'h0041;
    step();
    chk("t5_fault", {15'd0, fault}, 16'd1);
    chk("t5_valid", {15'd0, ir_valid}, 16'd0);
    chk("t5_pc", pc, 16'h0002);
    redirect_pc = 16'h0000;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t5_sticky", {15'd0, fault}, 16'd1);
    chk("t5_pc_hold", pc, 16'h0002);
    chk("t5_addr_hold", imem_addr, 16'h0002);
    chk("t5_novalid", {15'd0, ir_valid}, 16'd0);
    rst = 1'b1;
    step();
    chk("t5_clear", {15'd0, fault}, 16'd0);
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    chk("t5_range_fault", {15'd0, fault}, 16'd1);
    chk("t5_range_pc", pc, 16'h0000);
    redirect_valid = 1'b0; rst = 1'b1;
    step();
    chk("t5_clear2", {15'd0, fault}, 16'd0);

    // 6: top-of-memory wrap, then reset during a stall
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h00FE;
    step();
    chk("t6_pcFE", pc, 16'h00FE);
    redirect_valid = 1'b0; ir_ready = 1'b1;
    step();
    chk("t6_irpcFE", ir_pc, 16'h00FE);
    chk("t6_dataFE", ir_data, 16'hA55A);
    chk("t6_wrap_pc", pc, 16'h0000);
    step();
    chk("t6_irpc0", ir_pc, 16'h0000);
    chk("t6_data0", ir_data, 16'hD118);
    ir_ready = 1'b0;
    step();
    chk("t6_stall", ir_data, 16'hD118);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", {15'd0, ir_valid}, 16'd0);
    chk("t6_rst_pc", pc, 16'h0000);
    chk("t6_rst_data", ir_data, 16'h0000);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so a hung run still ends with a report.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
